// File: rtl/sampler_readout_ctrl_if.sv
// sampler_readout_ctrl_if: command, sampler read port and output stream of the readout sequencer
interface sampler_readout_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic start, abort;
  logic [CNT_WIDTH-1:0] nwords;
  logic trig;
  logic [DATA_WIDTH-1:0] smp_dout;
  logic smp_empty, smp_rden;
  logic [DATA_WIDTH-1:0] m_data;
  logic m_valid, m_last, m_ready;
  logic busy, done, timeout_err;
  modport master (
    input start, abort, nwords, smp_dout, smp_empty, m_ready,
    output trig, smp_rden, m_data, m_valid, m_last, busy, done, timeout_err
  );
  modport slave (
    output start, abort, nwords, smp_dout, smp_empty, m_ready,
    input trig, smp_rden, m_data, m_valid, m_last, busy, done, timeout_err
  );
endinterface

// File: rtl/sampler_readout_ctrl.sv
// sampler_readout_ctrl: triggers the snapshot sampler, then drains it as a header/data/trailer frame
module sampler_readout_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 16,
  parameter int TRIG_CYCLES = 8,
  parameter int FILL_WAIT = 1024,
  parameter int TIMEOUT = 65535,
  parameter logic [15:0] HEADER_TAG = 16'h5A5A
) (
  input logic CLK,
  input logic RESET,
  sampler_readout_ctrl_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_FILL, S_HDR, S_DATA, S_TRL, S_DONE} state_t;
  state_t r_state;
  logic [CNT_WIDTH-1:0] r_nwords, r_rem, r_rd;
  logic [31:0] r_tmr;
  logic r_trig, r_m_valid, r_m_last, r_done, r_to, r_terr;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic w_rden, w_hs;
  logic [DATA_WIDTH-1:0] w_hdr, w_trl;
  assign w_hs = r_m_valid && bus.m_ready;
  // pop only when the output register is free or being emptied this cycle
  assign w_rden = (r_state == S_DATA) && !bus.abort && !r_to && !bus.smp_empty &&
                  (r_rem != '0) && (!r_m_valid || bus.m_ready);
  assign w_hdr = DATA_WIDTH'({HEADER_TAG, 16'(r_nwords)});
  assign w_trl = DATA_WIDTH'({8'hA5, 7'b0, r_to, 16'(r_rd)});
  assign bus.trig = r_trig;
  assign bus.smp_rden = w_rden;
  assign bus.m_data = r_m_data;
  assign bus.m_valid = r_m_valid;
  assign bus.m_last = r_m_last;
  assign bus.busy = r_state != S_IDLE;
  assign bus.done = r_done;
  assign bus.timeout_err = r_terr;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_nwords <= '0;
      r_rem <= '0;
      r_rd <= '0;
      r_tmr <= '0;
      r_trig <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last <= 1'b0;
      r_done <= 1'b0;
      r_to <= 1'b0;
      r_terr <= 1'b0;
      r_m_data <= '0;
    end else if (bus.abort) begin
      r_state <= S_IDLE;
      r_trig <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last <= 1'b0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state <= S_TRIG;
          r_trig <= 1'b1;
          r_tmr <= '0;
          r_nwords <= bus.nwords;
          r_rem <= bus.nwords;
          r_rd <= '0;
          r_to <= 1'b0;
          r_terr <= 1'b0;
        end
        S_TRIG: if (r_tmr == TRIG_CYCLES - 1) begin
          r_state <= S_FILL;
          r_trig <= 1'b0;
          r_tmr <= '0;
        end else r_tmr <= r_tmr + 1;
        S_FILL: if (r_tmr == FILL_WAIT - 1) begin
          r_state <= S_HDR;
          r_m_valid <= 1'b1;
          r_m_data <= w_hdr;
          r_tmr <= '0;
        end else r_tmr <= r_tmr + 1;
        S_HDR: if (w_hs) begin
          r_tmr <= '0;
          if (r_nwords == '0) begin
            r_state <= S_TRL;
            r_m_data <= w_trl;
            r_m_last <= 1'b1;
          end else begin
            r_state <= S_DATA;
            r_m_valid <= 1'b0;
          end
        end
        S_DATA: if (w_rden) begin
          r_m_data <= bus.smp_dout;
          r_m_valid <= 1'b1;
          r_rem <= r_rem - 1'b1;
          r_rd <= r_rd + 1'b1;
          r_tmr <= '0;
        end else begin
          if (w_hs) r_m_valid <= 1'b0;
          // trailer reuses the output register as soon as the last data word leaves
          if ((r_rem == '0 || r_to) && (!r_m_valid || bus.m_ready)) begin
            r_state <= S_TRL;
            r_m_data <= w_trl;
            r_m_valid <= 1'b1;
            r_m_last <= 1'b1;
          end else if (r_tmr == TIMEOUT - 1) begin
            r_to <= 1'b1;
            r_terr <= 1'b1;
          end else r_tmr <= r_tmr + 1;
        end
        S_TRL: if (w_hs) begin
          r_state <= S_DONE;
          r_m_valid <= 1'b0;
          r_m_last <= 1'b0;
          r_done <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sampler_readout_ctrl.sv
// tb_sampler_readout_ctrl: directed frames against a queue-backed sampler model and stream monitor
module tb_sampler_readout_ctrl;
  localparam int DW = 32;
  localparam int CW = 16;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;
  sampler_readout_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  sampler_readout_ctrl #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TRIG_CYCLES(8), .FILL_WAIT(16), .TIMEOUT(100), .HEADER_TAG(16'h5A5A)
  ) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  int checks = 0, fails = 0;
  logic [DW-1:0] mem [0:31];
  int avail = 0, ptr = 0, rd_pulses = 0, trig_cyc = 0, trig_rise = 0, done_cnt = 0, stall_err = 0;
  logic clr = 1'b0, prev_trig = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] got [$];
  logic got_last [$];
  assign bus.smp_dout = (ptr < 32) ? mem[ptr] : '0;
  assign bus.smp_empty = ptr >= avail;
  always @(posedge CLK) begin
    if (clr) begin
      ptr <= 0; rd_pulses <= 0; trig_cyc <= 0; trig_rise <= 0; done_cnt <= 0; stall_err <= 0;
    end else begin
      if (bus.smp_rden) begin ptr <= ptr + 1; rd_pulses <= rd_pulses + 1; end
      if (bus.trig) trig_cyc <= trig_cyc + 1;
      if (bus.trig && !prev_trig) trig_rise <= trig_rise + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) stall_err <= stall_err + 1;
      if (bus.m_valid && bus.m_ready) begin got.push_back(bus.m_data); got_last.push_back(bus.m_last); end
    end
    prev_trig <= bus.trig;
    prev_stall <= bus.m_valid && !bus.m_ready && !bus.abort;
    prev_data <= bus.m_data;
  end

  task automatic prep(input int nav, input logic [DW-1:0] base);
    @(negedge CLK);
    clr = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = base + DW'(i);
    avail = nav;
    got.delete(); got_last.delete();
    @(negedge CLK);
    clr = 1'b0;
  endtask

  task automatic run_frame(input logic [CW-1:0] n, input bit toggle, input int extra_start_at, output bit ok);
    bus.m_ready = 1'b1; bus.nwords = n; bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.start = (c == extra_start_at);
      if (toggle) bus.m_ready = ~bus.m_ready;
      @(negedge CLK);
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    bus.start = 1'b0; bus.m_ready = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bus.trig, bus.smp_rden, bus.m_valid, bus.m_last, bus.busy, bus.done, bus.timeout_err} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl got %b exp 0000000", {bus.trig, bus.smp_rden, bus.m_valid, bus.m_last, bus.busy, bus.done, bus.timeout_err});
    end
    checks++;
    if (bus.m_data !== '0) begin fails++; $display("FAIL reset_data got %h exp 0", bus.m_data); end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic;
    logic [DW-1:0] exp [$];
    bit ok;
    exp = '{32'h5A5A0004, 32'h1, 32'h2, 32'h3, 32'h4, 32'hA5000004};
    prep(4, 32'h1);
    run_frame(16'd4, 1'b0, -1, ok);
    checks++; if (!ok) begin fails++; $display("FAIL basic_done timed out"); end
    checks++; if (got.size() != exp.size()) begin fails++; $display("FAIL basic_len got %0d exp %0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got[i] !== exp[i] || got_last[i] !== (i == exp.size() - 1)) begin
        fails++; $display("FAIL basic_word%0d got %h last %b exp %h", i, got[i], got_last[i], exp[i]);
      end
    end
    checks++; if (trig_cyc != 8) begin fails++; $display("FAIL basic_trig_len got %0d exp 8", trig_cyc); end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (rd_pulses != 4) begin fails++; $display("FAIL basic_pops got %0d exp 4", rd_pulses); end
    checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin fails++; $display("FAIL basic_idle busy %b terr %b exp 0 0", bus.busy, bus.timeout_err); end
  endtask

  task automatic test_zero_words;
    logic [DW-1:0] exp [$];
    bit ok;
    exp = '{32'h5A5A0000, 32'hA5000000};
    prep(4, 32'h1);
    run_frame(16'd0, 1'b0, -1, ok);
    checks++; if (!ok) begin fails++; $display("FAIL zero_done timed out"); end
    checks++; if (got.size() != exp.size()) begin fails++; $display("FAIL zero_len got %0d exp %0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got[i] !== exp[i] || got_last[i] !== (i == 1)) begin
        fails++; $display("FAIL zero_word%0d got %h last %b exp %h", i, got[i], got_last[i], exp[i]);
      end
    end
    checks++; if (rd_pulses != 0) begin fails++; $display("FAIL zero_pops got %0d exp 0", rd_pulses); end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] exp [$];
    bit ok;
    exp.push_back(32'h5A5A0010);
    for (int i = 0; i < 16; i++) exp.push_back(32'h100 + DW'(i));
    exp.push_back(32'hA5000010);
    prep(16, 32'h100);
    run_frame(16'd16, 1'b1, -1, ok);
    checks++; if (!ok) begin fails++; $display("FAIL bp_done timed out"); end
    checks++; if (got.size() != exp.size()) begin fails++; $display("FAIL bp_len got %0d exp %0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL bp_word%0d got %h exp %h", i, got[i], exp[i]); end
    end
    checks++; if (stall_err != 0) begin fails++; $display("FAIL bp_stable got %0d unstable cycles exp 0", stall_err); end
    checks++; if (rd_pulses != 16) begin fails++; $display("FAIL bp_pops got %0d exp 16", rd_pulses); end
  endtask

  task automatic test_timeout;
    logic [DW-1:0] exp [$];
    bit ok;
    exp = '{32'h5A5A0008, 32'h1, 32'h2, 32'h3, 32'hA5010003};
    prep(3, 32'h1);
    run_frame(16'd8, 1'b0, -1, ok);
    checks++; if (!ok) begin fails++; $display("FAIL to_done timed out"); end
    checks++; if (got.size() != exp.size()) begin fails++; $display("FAIL to_len got %0d exp %0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL to_word%0d got %h exp %h", i, got[i], exp[i]); end
    end
    checks++; if (bus.timeout_err !== 1'b1) begin fails++; $display("FAIL to_err got %b exp 1", bus.timeout_err); end
    bus.abort = 1'b1;
    @(negedge CLK);
    bus.abort = 1'b0;
    checks++; if (bus.timeout_err !== 1'b1) begin fails++; $display("FAIL to_sticky_abort got %b exp 1", bus.timeout_err); end
  endtask

  task automatic test_abort;
    logic [DW-1:0] exp [$];
    bit ok;
    prep(8, 32'h1);
    bus.m_ready = 1'b1; bus.nwords = 16'd8; bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    for (int c = 0; c < 200 && rd_pulses == 0; c++) @(negedge CLK);
    bus.m_ready = 1'b0;
    checks++; if (bus.m_valid !== 1'b1 || rd_pulses == 0) begin fails++; $display("FAIL abort_setup valid %b pops %0d exp 1 >0", bus.m_valid, rd_pulses); end
    checks++; if (bus.timeout_err !== 1'b0) begin fails++; $display("FAIL abort_err_cleared got %b exp 0", bus.timeout_err); end
    bus.abort = 1'b1;
    #1;
    checks++; if (bus.smp_rden !== 1'b0) begin fails++; $display("FAIL abort_rden got %b exp 0", bus.smp_rden); end
    @(negedge CLK);
    bus.abort = 1'b0; bus.m_ready = 1'b1;
    checks++; if ({bus.m_valid, bus.busy, bus.trig, bus.m_last} !== 4'b0) begin fails++; $display("FAIL abort_outputs got %b exp 0000", {bus.m_valid, bus.busy, bus.trig, bus.m_last}); end
    repeat (5) @(negedge CLK);
    checks++; if (done_cnt != 0) begin fails++; $display("FAIL abort_no_done got %0d exp 0", done_cnt); end
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL start_abort_same got busy %b exp 0", bus.busy); end
    exp = '{32'h5A5A0003, 32'h1, 32'h2, 32'h3, 32'hA5000003};
    prep(3, 32'h1);
    run_frame(16'd3, 1'b0, -1, ok);
    checks++; if (!ok || done_cnt != 1) begin fails++; $display("FAIL abort_clean_done ok %b done %0d exp 1 1", ok, done_cnt); end
    checks++; if (got.size() != exp.size()) begin fails++; $display("FAIL abort_clean_len got %0d exp %0d", got.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL abort_clean_word%0d got %h exp %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_start_in_fill;
    bit ok;
    prep(2, 32'h1);
    run_frame(16'd2, 1'b0, 12, ok);
    repeat (40) @(negedge CLK);
    checks++; if (trig_rise != 1 || trig_cyc != 8) begin fails++; $display("FAIL fill_start_trig rises %0d cycles %0d exp 1 8", trig_rise, trig_cyc); end
    checks++; if (!ok || done_cnt != 1) begin fails++; $display("FAIL fill_start_done ok %b done %0d exp 1 1", ok, done_cnt); end
    checks++; if (got.size() != 4) begin fails++; $display("FAIL fill_start_len got %0d exp 4", got.size()); end
  endtask

  task automatic test_reset_mid_frame;
    prep(4, 32'h1);
    bus.nwords = 16'd4; bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++; if ({bus.trig, bus.busy, bus.m_valid} !== 3'b0) begin fails++; $display("FAIL reset_mid got %b exp 000", {bus.trig, bus.busy, bus.m_valid}); end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.nwords = '0; bus.m_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset;
    test_basic;
    test_zero_words;
    test_backpressure;
    test_timeout;
    test_abort;
    test_start_in_fill;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
